// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock-enable/divider: per-channel period/high time,
// registered divided level and one-cycle wrap tick, with shadowed runtime config.
module clk_div_prog #(
    parameter int unsigned             NUM_CH     = 2,
    parameter int unsigned             CNT_W      = 32,
    parameter logic [CNT_W-1:0]        DEF_PERIOD = 10_000_000,
    parameter logic [CNT_W-1:0]        DEF_HIGH   = 5_000_000,
    localparam int unsigned            CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic DEF_OUT = (DEF_PERIOD != '0) && (DEF_HIGH != '0);

    logic [NUM_CH-1:0] pending;

    // An out-of-range channel index is never accepted.
    assign cfg_ready = (int'(cfg_ch) < int'(NUM_CH)) ? ~pending[cfg_ch] : 1'b0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] p_q, p_d;
        logic [CNT_W-1:0] h_q, h_d;
        logic [CNT_W-1:0] sp_q, sh_q;
        logic             pend_q, pend_d;
        logic             out_q, out_d;
        logic             tick_q, tick_d;
        logic             accept, wrap, apply;

        assign accept = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
        assign wrap   = (p_q != '0) && (cnt_q == p_q - CNT_W'(1));

        always_comb begin
            cnt_d  = cnt_q;
            p_d    = p_q;
            h_d    = h_q;
            tick_d = 1'b0;
            apply  = 1'b0;
            if (restart) begin
                cnt_d = '0;
                apply = pend_q;
            end else if (p_q == '0) begin
                cnt_d = '0;
                apply = pend_q;
            end else if (en) begin
                cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
                tick_d = wrap;
                apply  = wrap && pend_q;
            end
            if (apply) begin
                p_d = sp_q;
                h_d = sh_q;
            end
            // accept needs pend_q==0 and apply needs pend_q==1, so they never collide
            pend_d = accept | (pend_q & ~apply);
            out_d  = (p_d != '0) && (cnt_d < h_d);
        end

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                cnt_q  <= '0;
                p_q    <= DEF_PERIOD;
                h_q    <= DEF_HIGH;
                sp_q   <= DEF_PERIOD;
                sh_q   <= DEF_HIGH;
                pend_q <= 1'b0;
                out_q  <= DEF_OUT;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                p_q    <= p_d;
                h_q    <= h_d;
                pend_q <= pend_d;
                out_q  <= out_d;
                tick_q <= tick_d;
                if (accept) begin
                    sp_q <= cfg_period;
                    sh_q <= cfg_high;
                end
            end
        end

        assign pending[g] = pend_q;
        assign clk_out[g] = out_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random traffic,
// compared each cycle against a behavioural per-channel model.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       en;
    logic       restart;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic [1:0] clk_out;
    logic [1:0] tick;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_cnt[2], m_p[2], m_h[2], m_sp[2], m_sh[2];
    bit m_pend[2], m_tick[2];

    always #5 clk = ~clk;

    clk_div_prog #(
        .NUM_CH(2), .CNT_W(8), .DEF_PERIOD(8'd4), .DEF_HIGH(8'd2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .restart(restart),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high),
        .clk_out(clk_out), .tick(tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_p[i] = 4; m_h[i] = 2;
            m_sp[i] = 4; m_sh[i] = 2; m_pend[i] = 0; m_tick[i] = 0;
        end
    endfunction

    function automatic logic [1:0] m_out();
        logic [1:0] o;
        for (int i = 0; i < 2; i++) o[i] = (m_p[i] != 0) && (m_cnt[i] < m_h[i]);
        return o;
    endfunction

    function automatic logic [1:0] m_tickv();
        return {m_tick[1], m_tick[0]};
    endfunction

    function automatic void m_step(input bit e, input bit rs, input bit acc,
                                   input int ch, input int per, input int hi);
        for (int i = 0; i < 2; i++) begin
            bit app;
            app = 0;
            m_tick[i] = 0;
            if (rs || m_p[i] == 0) begin
                m_cnt[i] = 0;
                app = m_pend[i];
            end else if (e) begin
                if (m_cnt[i] == m_p[i] - 1) begin
                    m_cnt[i] = 0; m_tick[i] = 1; app = m_pend[i];
                end else begin
                    m_cnt[i]++;
                end
            end
            if (app) begin
                m_p[i] = m_sp[i]; m_h[i] = m_sh[i]; m_pend[i] = 0;
            end
            if (acc && ch == i) begin
                m_sp[i] = per; m_sh[i] = hi; m_pend[i] = 1;
            end
        end
    endfunction

    // One clock: check handshake before the edge, advance model, check outputs after.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            bit exp_ready, acc;
            @(negedge clk);
            exp_ready = !m_pend[int'(cfg_ch)];
            chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
            acc = cfg_valid && exp_ready;
            @(posedge clk);
            #1;
            m_step(en, restart, acc, int'(cfg_ch), int'(cfg_period), int'(cfg_high));
            chk("clk_out", 32'(clk_out), 32'(m_out()));
            chk("tick", 32'(tick), 32'(m_tickv()));
        end
    endtask

    task automatic write_cfg(input int ch, input int per, input int hi);
        cfg_ch = 1'(ch); cfg_period = 8'(per); cfg_high = 8'(hi);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int ch, input int val);
        int n;
        n = 0;
        while (m_cnt[ch] != val && n < 40) begin
            step(1);
            n++;
        end
        chk("wait_cnt_timeout", 32'(m_cnt[ch] == val), 32'd1);
    endtask

    initial begin
        n_rst = 1'b0; en = 1'b0; restart = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 1'b0; cfg_period = '0; cfg_high = '0;
        m_reset();
        #12;
        chk("reset_clk_out", 32'(clk_out), 32'h3);
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_ready", 32'(cfg_ready), 32'h1);
        @(posedge clk); #1;
        n_rst = 1'b1; en = 1'b1;

        // default pattern 1,1,0,0 with first tick four cycles after release
        for (int k = 0; k < 4; k++) begin
            chk("pattern0", 32'(clk_out[0]), 32'(k < 2));
            chk("no_early_tick", 32'(tick[0]), 32'h0);
            step(1);
        end
        chk("first_tick", 32'(tick[0]), 32'h1);
        step(8);

        // ch1 reprogram mid-period
        wait_cnt(1, 1);
        write_cfg(1, 6, 3);
        cfg_ch = 1'b1;
        step(20);

        // ch0 disable, then re-enable with 3/1
        cfg_ch = 1'b0;
        write_cfg(0, 0, 2);
        step(8);
        chk("ch0_disabled_out", 32'(clk_out[0]), 32'h0);
        write_cfg(0, 3, 1);
        step(9);

        // edge settings
        write_cfg(0, 4, 5);
        step(12);
        write_cfg(1, 1, 1);
        step(10);
        chk("p1_tick", 32'(tick[1]), 32'h1);
        write_cfg(0, 4, 0);
        step(10);
        chk("h0_out", 32'(clk_out[0]), 32'h0);

        // en low for 7 cycles mid-period
        write_cfg(0, 5, 2);
        step(8);
        wait_cnt(0, 1);
        en = 1'b0;
        step(7);
        en = 1'b1;
        step(6);

        // restart with ch0 write pending
        wait_cnt(0, 1);
        write_cfg(0, 7, 4);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_tick", 32'(tick), 32'h0);
        step(10);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            en         = ($urandom_range(0, 9) != 0);
            restart    = ($urandom_range(0, 29) == 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 1'($urandom_range(0, 1));
            cfg_period = 8'($urandom_range(0, 7));
            cfg_high   = 8'($urandom_range(0, 8));
            step(1);
        end
        en = 1'b1; restart = 1'b0; cfg_valid = 1'b0;
        step(5);

        // asynchronous reset mid-period
        #2;
        n_rst = 1'b0;
        #1;
        m_reset();
        chk("async_rst_clk_out", 32'(clk_out), 32'h3);
        chk("async_rst_tick", 32'(tick), 32'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
